// File: rtl/pagamento_moedas_if.sv
// Payment-stage bundle between the coffee-machine control FSM (master) and the
// coin front-end (slave).
interface pagamento_moedas_if;
  logic       ATIVO;
  logic       PRODUTO;
  logic [1:0] MOEDA;
  logic       CONFIRMA_PAG;
  logic [1:0] S_PAGAMENTO;
  logic       TIMER_PAG;
  logic [7:0] CREDITO;
  logic [7:0] TROCO;
  logic       REJEITA;

  modport master (
    output ATIVO, PRODUTO, MOEDA, CONFIRMA_PAG,
    input  S_PAGAMENTO, TIMER_PAG, CREDITO, TROCO, REJEITA
  );

  modport slave (
    input  ATIVO, PRODUTO, MOEDA, CONFIRMA_PAG,
    output S_PAGAMENTO, TIMER_PAG, CREDITO, TROCO, REJEITA
  );
endinterface

// File: rtl/pagamento_moedas.sv
// Coin payment front-end: edge-detects coin/confirm inputs, accumulates credit
// against the latched drink price and reports status, change and timeout.
module pagamento_moedas #(
  parameter int unsigned PRECO_0        = 150,
  parameter int unsigned PRECO_1        = 200,
  parameter int unsigned MAX_CREDITO    = 250,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  pagamento_moedas_if.slave pag
);
  localparam int unsigned CW = $clog2(TIMEOUT_CICLOS);

  typedef enum logic [2:0] {
    IDLE, COLETANDO, APROVADO, RECUSADO, EXPIRADO
  } estado_t;

  typedef struct packed {
    logic [1:0] status;
    logic       timer;
    logic [7:0] troco;
    logic       rejeita;
  } saida_t;

  function automatic logic [7:0] valor_moeda(input logic [1:0] m);
    case (m)
      2'b01:   return 8'd25;
      2'b10:   return 8'd50;
      2'b11:   return 8'd100;
      default: return 8'd0;
    endcase
  endfunction

  estado_t       estado_q, estado_d;
  logic [7:0]    preco_q, preco_d;
  logic [7:0]    credito_q, credito_d;
  logic [CW-1:0] cnt_q, cnt_d;
  saida_t        saida_q, saida_d;
  logic [1:0]    moeda_q;
  logic          conf_q;

  logic          evento_moeda, evento_conf, aceita, cabe;
  logic [7:0]    valor;
  logic [8:0]    soma, total;

  // A coin only counts when the switch leaves 00; 01<->10 slides are ignored.
  assign evento_moeda = (moeda_q == 2'b00) && (pag.MOEDA != 2'b00);
  assign evento_conf  = !conf_q && pag.CONFIRMA_PAG;
  assign valor        = valor_moeda(pag.MOEDA);
  assign soma         = {1'b0, credito_q} + {1'b0, valor};
  assign cabe         = soma <= 9'(MAX_CREDITO);
  assign aceita       = (estado_q == COLETANDO) && evento_moeda && cabe;
  assign total        = aceita ? soma : {1'b0, credito_q};

  always_comb begin
    estado_d        = estado_q;
    preco_d         = preco_q;
    credito_d       = credito_q;
    cnt_d           = cnt_q;
    saida_d         = saida_q;
    saida_d.timer   = 1'b0;
    saida_d.rejeita = 1'b0;

    if (estado_q != IDLE && !pag.ATIVO) begin
      estado_d  = IDLE;
      credito_d = '0;
      cnt_d     = '0;
      saida_d   = '0;
    end else begin
      case (estado_q)
        IDLE: begin
          saida_d = '0;
          if (pag.ATIVO) begin
            preco_d   = pag.PRODUTO ? 8'(PRECO_1) : 8'(PRECO_0);
            credito_d = '0;
            cnt_d     = '0;
            estado_d  = COLETANDO;
          end
        end

        COLETANDO: begin
          saida_d.status = 2'b00;
          if (aceita) begin
            credito_d = soma[7:0];
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (evento_moeda) saida_d.rejeita = 1'b1;
          end
          // Confirm outranks the timeout; the coin seen this cycle joins the total.
          if (evento_conf) begin
            if (total >= {1'b0, preco_q}) begin
              estado_d       = APROVADO;
              saida_d.status = 2'b11;
              saida_d.troco  = total[7:0] - preco_q;
            end else begin
              estado_d       = RECUSADO;
              saida_d.status = 2'b01;
            end
          end else if (!aceita && cnt_q == CW'(TIMEOUT_CICLOS - 1)) begin
            saida_d.timer = 1'b1;
            estado_d      = EXPIRADO;
          end
        end

        APROVADO, RECUSADO: begin
          if (evento_moeda) saida_d.rejeita = 1'b1;
        end

        EXPIRADO: begin
          saida_d.status = 2'b00;
        end

        default: begin
          estado_d  = IDLE;
          credito_d = '0;
          cnt_d     = '0;
          saida_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado_q  <= IDLE;
      preco_q   <= '0;
      credito_q <= '0;
      cnt_q     <= '0;
      saida_q   <= '0;
      moeda_q   <= 2'b00;
      conf_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      preco_q   <= preco_d;
      credito_q <= credito_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      moeda_q   <= pag.MOEDA;
      conf_q    <= pag.CONFIRMA_PAG;
    end
  end

  assign pag.S_PAGAMENTO = saida_q.status;
  assign pag.TIMER_PAG   = saida_q.timer;
  assign pag.CREDITO     = credito_q;
  assign pag.TROCO       = saida_q.troco;
  assign pag.REJEITA     = saida_q.rejeita;
endmodule

// File: tb/tb_pagamento_moedas.sv
// Scoreboard bench for pagamento_moedas: directed scenarios plus random coins,
// expected outputs from a cents-level reference model, checked every cycle.
module tb_pagamento_moedas;
  localparam int T   = 10;
  localparam int P0  = 150;
  localparam int P1  = 200;
  localparam int MAX = 250;

  localparam int M_IDLE = 0, M_COL = 1, M_APR = 2, M_REC = 3, M_EXP = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pagamento_moedas_if pag();

  pagamento_moedas #(
    .PRECO_0(P0), .PRECO_1(P1), .MAX_CREDITO(MAX), .TIMEOUT_CICLOS(T)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pag(pag)
  );

  typedef struct {
    int unsigned due;
    logic [1:0]  st;
    logic        tmr;
    logic [7:0]  cred;
    logic [7:0]  troco;
    logic        rej;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned ncyc  = 0;

  always @(posedge CLK) ncyc <= ncyc + 1;

  // Reference model state (cents and plain counters).
  int   m_mode, m_price, m_credit, m_troco, m_status, m_idle;
  logic m_tmr, m_rej;
  logic [1:0] m_pm;
  logic m_pc;

  function automatic int cents(input logic [1:0] m);
    return (m == 2'b01) ? 25 : (m == 2'b10) ? 50 : (m == 2'b11) ? 100 : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_price = 0; m_credit = 0; m_troco = 0; m_status = 0;
    m_idle = 0; m_tmr = 1'b0; m_rej = 1'b0; m_pm = 2'b00; m_pc = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic p, input logic [1:0] m, input logic c);
    bit coin_ev, conf_ev, got;
    int v;
    coin_ev = (m_pm == 2'b00) && (m != 2'b00);
    conf_ev = !m_pc && c;
    v       = cents(m);
    got     = 1'b0;
    m_tmr   = 1'b0;
    m_rej   = 1'b0;
    if (m_mode != M_IDLE && !a) begin
      m_mode = M_IDLE; m_credit = 0; m_troco = 0; m_status = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (a) begin
          m_price = p ? P1 : P0; m_credit = 0; m_idle = 0; m_mode = M_COL;
        end
        M_COL: begin
          if (coin_ev) begin
            if (m_credit + v <= MAX) begin m_credit += v; got = 1'b1; m_idle = 0; end
            else m_rej = 1'b1;
          end
          if (!got) m_idle++;
          if (conf_ev) begin
            if (m_credit >= m_price) begin
              m_mode = M_APR; m_status = 3; m_troco = m_credit - m_price;
            end else begin
              m_mode = M_REC; m_status = 1;
            end
          end else if (m_idle == T) begin
            m_tmr = 1'b1; m_mode = M_EXP;
          end
        end
        M_APR, M_REC: if (coin_ev) m_rej = 1'b1;
        default: ;
      endcase
    end
    m_pm = m;
    m_pc = c;
  endtask

  // One clock of stimulus: drive, predict, queue the expectation for the next edge.
  task automatic cyc(input logic a, input logic p, input logic [1:0] m, input logic c);
    exp_t e;
    pag.ATIVO = a; pag.PRODUTO = p; pag.MOEDA = m; pag.CONFIRMA_PAG = c;
    model_step(a, p, m, c);
    e.due = ncyc + 1; e.st = 2'(m_status); e.tmr = m_tmr; e.cred = 8'(m_credit);
    e.troco = 8'(m_troco); e.rej = m_rej;
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic coin(input logic p, input logic [1:0] m, input int hold);
    repeat (hold) cyc(1'b1, p, m, 1'b0);
    cyc(1'b1, p, 2'b00, 1'b0);
  endtask

  task automatic idle_n(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic reset_mid();
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    n_vec++;
    if ({pag.S_PAGAMENTO, pag.TIMER_PAG, pag.CREDITO, pag.TROCO, pag.REJEITA} !== 20'd0) begin
      n_err++;
      $display("FAIL async_reset t=%0t: st=%b tmr=%b cred=%0d troco=%0d rej=%b, expected all zero",
               $time, pag.S_PAGAMENTO, pag.TIMER_PAG, pag.CREDITO, pag.TROCO, pag.REJEITA);
    end
    pag.ATIVO = 1'b0; pag.PRODUTO = 1'b0; pag.MOEDA = 2'b00; pag.CONFIRMA_PAG = 1'b0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].due <= ncyc) begin
        mon_e = q.pop_front();
        n_vec++;
        if ({pag.S_PAGAMENTO, pag.TIMER_PAG, pag.CREDITO, pag.TROCO, pag.REJEITA} !==
            {mon_e.st, mon_e.tmr, mon_e.cred, mon_e.troco, mon_e.rej}) begin
          n_err++;
          $display("FAIL outputs cyc=%0d: st=%b tmr=%b cred=%0d troco=%0d rej=%b, expected st=%b tmr=%b cred=%0d troco=%0d rej=%b",
                   ncyc, pag.S_PAGAMENTO, pag.TIMER_PAG, pag.CREDITO, pag.TROCO, pag.REJEITA,
                   mon_e.st, mon_e.tmr, mon_e.cred, mon_e.troco, mon_e.rej);
        end
      end
    end
  end

  initial begin
    logic       ra, rc, rp;
    logic [1:0] rm;
    int         hold;

    pag.ATIVO = 1'b0; pag.PRODUTO = 1'b0; pag.MOEDA = 2'b00; pag.CONFIRMA_PAG = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    idle_n(2);

    // Product 0: 100 + 50, confirm -> approved with no change.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    coin(1'b0, 2'b11, 2);
    coin(1'b0, 2'b10, 1);
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b0, 2'b01, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(2);

    // Product 1: 100 then confirm -> refused, credit shown; drop ATIVO.
    cyc(1'b1, 1'b1, 2'b00, 1'b0);
    coin(1'b1, 2'b11, 1);
    cyc(1'b1, 1'b1, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 2'b00, 1'b0);
    idle_n(2);

    // Ceiling: 100,100 accepted, third 100 rejected; confirm -> change 50.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    coin(1'b0, 2'b11, 1);
    coin(1'b0, 2'b11, 3);
    coin(1'b0, 2'b11, 1);
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    coin(1'b0, 2'b01, 1);
    idle_n(2);

    // Timeout with no coins, then with a coin at cycle 5.
    repeat (T + 3) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    coin(1'b0, 2'b01, 1);
    repeat (T + 2) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(1);

    // Coin and confirm rising together: 100 + 50 against price 150.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    coin(1'b0, 2'b11, 1);
    cyc(1'b1, 1'b0, 2'b10, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(1);

    // Confirm on the very edge the timeout would fire.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (T - 1) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(1);

    // Held 25c for 20 cycles is one coin; 01<->10 slide is not a new coin.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    idle_n(1);

    // Async reset mid-collection with 75c credited.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    coin(1'b0, 2'b01, 1);
    coin(1'b0, 2'b10, 1);
    reset_mid();
    idle_n(2);

    ra = 1'b0; rc = 1'b0; rm = 2'b00; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ra && $urandom_range(0, 3) == 0) ra = 1'b1;
      else if (ra && $urandom_range(0, 49) == 0) ra = 1'b0;
      if (hold == 0) begin
        rm   = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
        hold = $urandom_range(1, 4);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 9) == 0) rc = ~rc;
      rp = 1'($urandom_range(0, 1));
      cyc(ra, rp, rm, rc);
      if ($urandom_range(0, 499) == 0) begin
        reset_mid();
        ra = 1'b0; rc = 1'b0; rm = 2'b00; hold = 0;
      end
    end

    idle_n(3);
    @(negedge CLK); #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
